// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//
// Purpose:
//   Turns a parallel word into a framed 1-bit stream: one start bit (0),
//   DATA_W data bits LSB-first, one stop bit (1). Each bit is held for
//   BIT_TICKS clocks. The line idles high. A new word can be accepted in the
//   last stop cycle, so back-to-back frames have no idle gap.
//
// Handshake (valid/ready):
//   A word is transferred on a rising edge where tx_valid && tx_ready.
//   tx_data only needs to be stable in that cycle. tx_valid may be held high
//   while tx_ready is low; the word then waits, and nothing is lost or sent
//   twice. tx_valid going low during a frame does not affect that frame.
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous, active-low reset
//   tx_data    in   [DATA_W-1:0] word to send, sampled on the accept edge
//   tx_valid   in   upstream has a word
//   tx_ready   out  word can be accepted this cycle (combinational)
//   tx_out     out  serial line, decoded from registered state only
//   busy       out  frame in progress (state != IDLE)
//   curr_state out  [1:0] debug view of the state register
// -----------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int BIT_TICKS = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic [1:0]        curr_state
);

    localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int BIT_W  = (DATA_W > 1)    ? $clog2(DATA_W)    : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_shift;
    logic [TICK_W-1:0]  r_tick;
    logic [BIT_W-1:0]   r_bit;

    logic               w_last_tick;
    logic               w_last_bit;
    logic               w_accept;

    assign w_last_tick = (r_tick == TICK_W'(BIT_TICKS - 1));
    assign w_last_bit  = (r_bit == BIT_W'(DATA_W - 1));

    // Ready is open in IDLE and in the final cycle of the stop bit, which is
    // what lets the next frame's start bit follow the stop bit directly.
    assign tx_ready = (r_state == IDLE) || ((r_state == STOP) && w_last_tick);
    assign w_accept = tx_valid && tx_ready;

    // Decoded from the state register only; because reset clears the state
    // asynchronously, the line goes high immediately when resetn drops.
    assign tx_out     = (r_state == DATA) ? r_shift[0] : (r_state != START);
    assign busy       = (r_state != IDLE);
    assign curr_state = r_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_tick  <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift <= tx_data;
                        r_tick  <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_last_tick) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_state <= DATA;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                DATA: begin
                    if (w_last_tick) begin
                        r_tick  <= '0;
                        r_shift <= r_shift >> 1;
                        if (w_last_bit) begin
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                STOP: begin
                    if (w_last_tick) begin
                        r_tick <= '0;
                        if (w_accept) begin
                            r_shift <= tx_data;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Two instances: dut_a with default parameters (DATA_W=8, BIT_TICKS=4) and
// dut_b with DATA_W=4, BIT_TICKS=1. For each, a per-cycle expected queue holds
// {state[1:0], ready, tx_out}. When the bench sees its own model of ready
// together with tx_valid, it pushes the whole expected frame; a negedge
// monitor pops one entry per cycle (or expects idle if empty) and compares.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

    localparam int A_DW = 8;
    localparam int A_BT = 4;
    localparam int B_DW = 4;
    localparam int B_BT = 1;
    localparam logic [3:0] IDLE_E = 4'b0011;

    logic             clk;
    logic             resetn;
    logic [A_DW-1:0]  a_data;
    logic             a_valid;
    logic             a_ready;
    logic             a_out;
    logic             a_busy;
    logic [1:0]       a_state;
    logic [B_DW-1:0]  b_data;
    logic             b_valid;
    logic             b_ready;
    logic             b_out;
    logic             b_busy;
    logic [1:0]       b_state;

    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];
    int         acc_a;
    int         acc_b;
    int         n_checks;
    int         n_fails;

    serial_frame_tx #(.DATA_W(A_DW), .BIT_TICKS(A_BT)) dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .tx_data    (a_data),
        .tx_valid   (a_valid),
        .tx_ready   (a_ready),
        .tx_out     (a_out),
        .busy       (a_busy),
        .curr_state (a_state)
    );

    serial_frame_tx #(.DATA_W(B_DW), .BIT_TICKS(B_BT)) dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .tx_data    (b_data),
        .tx_valid   (b_valid),
        .tx_ready   (b_ready),
        .tx_out     (b_out),
        .busy       (b_busy),
        .curr_state (b_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, req);
        end
    endtask

    // Build the expected per-cycle entries of one frame.
    task automatic push_frame(input int which, input logic [7:0] d,
                              input int dw, input int bt);
        logic [3:0] e;
        for (int t = 0; t < bt; t++) begin
            e = 4'b0100;
            if (which == 0) exp_a.push_back(e); else exp_b.push_back(e);
        end
        for (int i = 0; i < dw; i++) begin
            for (int t = 0; t < bt; t++) begin
                e = {2'b10, 1'b0, d[i]};
                if (which == 0) exp_a.push_back(e); else exp_b.push_back(e);
            end
        end
        for (int t = 0; t < bt; t++) begin
            e = {2'b11, (t == bt - 1), 1'b1};
            if (which == 0) exp_a.push_back(e); else exp_b.push_back(e);
        end
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        logic [3:0] e;
        if (!resetn) begin
            exp_a.delete();
            e = IDLE_E;
        end else if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
        end else begin
            e = IDLE_E;
        end
        check_eq("a_tx_out", 32'(a_out), 32'(e[0]));
        check_eq("a_ready", 32'(a_ready), 32'(e[1]));
        check_eq("a_state", 32'(a_state), 32'(e[3:2]));
        check_eq("a_busy", 32'(a_busy), 32'(e[3:2] != 2'b00));
        if (resetn && a_valid && e[1]) begin
            push_frame(0, a_data, A_DW, A_BT);
            acc_a++;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (!resetn) begin
            exp_b.delete();
            e = IDLE_E;
        end else if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
        end else begin
            e = IDLE_E;
        end
        check_eq("b_tx_out", 32'(b_out), 32'(e[0]));
        check_eq("b_ready", 32'(b_ready), 32'(e[1]));
        check_eq("b_state", 32'(b_state), 32'(e[3:2]));
        check_eq("b_busy", 32'(b_busy), 32'(e[3:2] != 2'b00));
        if (resetn && b_valid && e[1]) begin
            push_frame(1, {4'h0, b_data}, B_DW, B_BT);
            acc_b++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_acc_a(input int target, input int budget);
        int k;
        k = 0;
        while (acc_a < target && k < budget) begin
            step(1);
            k++;
        end
        check_eq("a_accept_count", 32'(acc_a), 32'(target));
    endtask

    task automatic wait_acc_b(input int target, input int budget);
        int k;
        k = 0;
        while (acc_b < target && k < budget) begin
            step(1);
            k++;
        end
        check_eq("b_accept_count", 32'(acc_b), 32'(target));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fails  = 0;
        acc_a    = 0;
        acc_b    = 0;
        resetn   = 1'b0;
        a_valid  = 1'b0;
        a_data   = '0;
        b_valid  = 1'b0;
        b_data   = '0;
        step(3);
        resetn = 1'b1;

        // Idle with no valid.
        step(10);

        // Single frame 0xA5.
        a_data  = 8'hA5;
        a_valid = 1'b1;
        wait_acc_a(1, 5);
        a_valid = 1'b0;
        step(45);

        // Back-to-back: 0xA5 then 0x3C with no idle gap.
        a_data  = 8'hA5;
        a_valid = 1'b1;
        wait_acc_a(2, 5);
        a_data = 8'h3C;
        wait_acc_a(3, 60);
        a_valid = 1'b0;
        step(45);

        // Stall: valid held with 0xFF, data changes to 0x00 mid-frame.
        a_data  = 8'hFF;
        a_valid = 1'b1;
        wait_acc_a(4, 5);
        step(19);
        a_data = 8'h00;
        wait_acc_a(5, 60);
        a_valid = 1'b0;
        step(45);

        // Reset mid-frame: outputs return to idle without waiting for a clock.
        a_data  = 8'hA5;
        a_valid = 1'b1;
        wait_acc_a(6, 5);
        a_valid = 1'b0;
        step(14);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("a_async_tx_out", 32'(a_out), 32'd1);
        check_eq("a_async_busy", 32'(a_busy), 32'd0);
        check_eq("a_async_state", 32'(a_state), 32'd0);
        step(2);
        resetn = 1'b1;
        step(2);
        a_data  = 8'h01;
        a_valid = 1'b1;
        wait_acc_a(7, 5);
        a_valid = 1'b0;
        step(45);

        // DATA_W=4, BIT_TICKS=1: 0x9 then back-to-back 0x6.
        b_data  = 4'h9;
        b_valid = 1'b1;
        wait_acc_b(1, 5);
        b_data = 4'h6;
        wait_acc_b(2, 20);
        b_valid = 1'b0;
        step(10);

        // Random words with random valid gaps on both instances.
        for (int w = 0; w < 6; w++) begin
            a_data  = 8'($urandom_range(0, 255));
            b_data  = 4'($urandom_range(0, 15));
            a_valid = 1'b1;
            b_valid = 1'b1;
            wait_acc_a(8 + w, 60);
            a_valid = 1'b0;
            b_valid = 1'b0;
            step($urandom_range(0, 3));
        end
        step(50);

        check_eq("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check_eq("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
